distributor: RTL and testbench
==============================

Name: distributor

Overview:
- One-to-many counterpart of the round-robin arbitor. Takes a single valid/stall stream and routes each word to one of NUM_OUT downstream channels.
- Each word goes either to an explicit destination ID or, for ANY-tagged words, round-robin to the next channel with space.
- Each channel has its own small first-word-fall-through FIFO, so one stalled consumer does not block words bound for other channels.
- Sits between a shared producer (e.g. ray/shader dispatch) and replicated downstream units.

Parameters:
- NUM_OUT, 4, number of downstream channels (>=2).
- WIDTH, 10, payload width in bits.
- DEPTH, 2, entries per channel FIFO (>=1).
- ID_W, $clog2(NUM_OUT+1), width of the destination field. ANY code = all ones ({ID_W{1'b1}}).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- valid_us  in  1  upstream word present.
- stall_us  out  1  upstream word not accepted this cycle.
- dest_us  in  ID_W  destination channel, or the ANY code.
- data_us  in  WIDTH  payload.
- valid_ds  out  NUM_OUT  channel i head word present.
- stall_ds  in  NUM_OUT  channel i consumer not accepting.
- data_ds  out  NUM_OUT x WIDTH  channel i head word (packed [NUM_OUT-1:0][WIDTH-1:0]).
- drop  out  1  one-cycle pulse: a word with an invalid destination was consumed.

Behaviour:
- Transfer rules:
  - Upstream transfer occurs when valid_us & ~stall_us.
  - Downstream transfer (pop) on channel i occurs when valid_ds[i] & ~stall_ds[i].
  - stall_us is 0 whenever valid_us is 0; data_us/dest_us are ignored then.
- Full definition: full[i] = (count[i] == DEPTH), taken from the registered count.
  - A same-cycle pop does NOT free space for a same-cycle push.
  - There is no combinational path from stall_ds to stall_us.
- Directed word (dest_us < NUM_OUT): stall_us = full[dest_us]. If accepted, the word is written to FIFO dest_us.
- ANY word (dest_us == ANY):
  - Search channels rrptr, rrptr+1, ... (mod NUM_OUT); target = first non-full channel.
  - If all channels are full, stall_us = 1.
  - On an accepted ANY word, rrptr <= (target+1) mod NUM_OUT.
  - rrptr is unchanged on directed words, invalid words, stalls and idle cycles.
- Invalid word (NUM_OUT <= dest_us < ANY):
  - stall_us = 0; the word is consumed and discarded.
  - drop = 1 on the following cycle only. Back-to-back invalid words give back-to-back drop pulses.
- Channel FIFOs:
  - First-word fall-through: valid_ds[i] = (count[i] != 0), data_ds[i] = head entry.
  - A push at cycle t is visible on valid_ds/data_ds at t+1, so minimum latency is 1 cycle.
  - Per-channel order is preserved.
  - Simultaneous push and pop on a non-full channel leaves count unchanged. On an empty channel the pushed word becomes head at t+1.
  - Pointers wrap at DEPTH-1 -> 0 (DEPTH need not be a power of two).
  - data_ds[i] is don't-care when valid_ds[i] = 0.
- Counters: count[i] is $clog2(DEPTH+1) bits and never exceeds DEPTH or goes below 0. Pop on an empty channel is impossible by construction.
- Reset, at any time including mid-transfer:
  - All FIFOs are flushed; count = 0; pointers = 0.
  - valid_ds = 0, drop = 0, rrptr = 0.
  - stall_us follows the combinational rule, so it is 0 after reset.
  - In-flight words are lost. No output glitches after rst deasserts.
- Synthesis-excluded assertions:
  - No push into a full channel.
  - At most one channel written per cycle.
  - $onehot0 of the per-channel write enables.

Test Plan:
1. Reset (NUM_OUT=4, DEPTH=2): hold rst=0 for 3 cycles, then release -> valid_ds=4'b0000, drop=0, stall_us=0, rrptr=0. ANY word 0x011 -> appears on valid_ds[0] next cycle.
2. Directed backpressure: stall_ds[1]=1; send dest=1 words 0x0A1, 0x0A2, 0x0A3 back-to-back -> first two accepted, stall_us=1 on 0x0A3 while count[1]=2. Release stall_ds[1] -> channel 1 emits 0x0A1, 0x0A2, 0x0A3 in order. Channel 3 directed traffic is accepted throughout.
3. ANY round-robin: stall_ds=0, send five ANY words 0x100..0x104 -> they land on channels 0,1,2,3,0. rrptr ends at 1. Each appears one cycle after acceptance.
4. ANY skip and all-full: fill channel 1 (stall_ds[1]=1, 2 entries) with rrptr=1; send ANY 0x200 -> lands on channel 2, rrptr=3. Then fill all channels with stall_ds=4'b1111 -> next ANY word sees stall_us=1 and rrptr holds.
5. Invalid destination: dest=5, data=0x3FF (ANY=7) -> stall_us=0, drop=1 exactly one cycle later, valid_ds unchanged. Two consecutive invalid words -> drop high for 2 cycles.
6. Full channel with concurrent pop: channel 0 full (count=2), stall_ds[0]=0 while a dest=0 word is offered -> stall_us=1 that cycle and count[0] becomes 1. Next cycle the word is accepted. Assert rst=0 mid-sequence -> all valid_ds drop immediately and rrptr=0.

Source files
------------

// File: rtl/distributor.sv
// One-to-many stream distributor: routes each upstream word to a directed
// channel or round-robin (ANY) to the next non-full channel, with per-channel FWFT FIFOs.
module distributor #(
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned ID_W    = $clog2(NUM_OUT + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_us,
    output logic                              stall_us,
    input  logic [ID_W-1:0]                   dest_us,
    input  logic [WIDTH-1:0]                  data_us,
    output logic [NUM_OUT-1:0]                valid_ds,
    input  logic [NUM_OUT-1:0]                stall_ds,
    output logic [NUM_OUT-1:0][WIDTH-1:0]     data_ds,
    output logic                              drop
);

    localparam int unsigned RR_W  = $clog2(NUM_OUT);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RR_W-1:0]    r_rrptr;
    logic               r_drop;
    logic [NUM_OUT-1:0] w_full;
    logic [NUM_OUT-1:0] w_wr_en;
    logic               w_is_dir;
    logic               w_is_any;
    logic               w_dir_full;
    logic               w_found;
    logic [RR_W-1:0]    w_target;
    logic               w_accept;

    assign w_is_dir = (32'(dest_us) < NUM_OUT);
    assign w_is_any = &dest_us;

    // Fullness of the addressed channel for directed words
    always_comb begin
        w_dir_full = 1'b0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (dest_us == ID_W'(i)) begin
                w_dir_full = w_full[i];
            end
        end
    end

    // First non-full channel starting at the round-robin pointer
    always_comb begin
        w_found  = 1'b0;
        w_target = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (!w_found && !w_full[(32'(r_rrptr) + k) % NUM_OUT]) begin
                w_found  = 1'b1;
                w_target = RR_W'((32'(r_rrptr) + k) % NUM_OUT);
            end
        end
    end

    always_comb begin
        stall_us = 1'b0;
        if (valid_us) begin
            if (w_is_dir) begin
                stall_us = w_dir_full;
            end else if (w_is_any) begin
                stall_us = ~w_found;
            end
        end
    end

    assign w_accept = valid_us & ~stall_us;

    always_comb begin
        w_wr_en = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (w_accept && ((w_is_dir && dest_us == ID_W'(i)) ||
                             (w_is_any && w_target == RR_W'(i)))) begin
                w_wr_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rrptr <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= valid_us & ~w_is_dir & ~w_is_any;
            if (w_accept && w_is_any) begin
                r_rrptr <= (w_target == RR_W'(NUM_OUT - 1)) ? '0 : w_target + RR_W'(1);
            end
        end
    end

    assign drop = r_drop;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        logic             w_pop;

        assign w_full[g]   = (r_count == CNT_W'(DEPTH));
        assign valid_ds[g] = (r_count != '0);
        assign data_ds[g]  = r_mem[r_rptr];
        assign w_pop       = valid_ds[g] & ~stall_ds[g];

        // Payload storage carries no reset; validity is governed by r_count
        always_ff @(posedge clk) begin
            if (w_wr_en[g]) begin
                r_mem[r_wptr] <= data_us;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_wr_en[g]) begin
                    r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
                end
                if (w_wr_en[g] && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_wr_en[g]) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end

`ifndef SYNTHESIS
        a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
            w_wr_en[g] |-> !w_full[g]);
`endif
    end

`ifndef SYNTHESIS
    a_wr_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(w_wr_en));
`endif

endmodule

// File: tb/tb_distributor.sv
// Randomized self-checking bench for distributor against a queue-based channel model.
module tb_distributor;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned WIDTH   = 10;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned ID_W    = 3;
    localparam logic [ID_W-1:0] ANY = 3'b111;

    logic                          clk;
    logic                          rst;
    logic                          valid_us;
    logic                          stall_us;
    logic [ID_W-1:0]               dest_us;
    logic [WIDTH-1:0]              data_us;
    logic [NUM_OUT-1:0]            valid_ds;
    logic [NUM_OUT-1:0]            stall_ds;
    logic [NUM_OUT-1:0][WIDTH-1:0] data_ds;
    logic                          drop;

    distributor #(.NUM_OUT(NUM_OUT), .WIDTH(WIDTH), .DEPTH(DEPTH), .ID_W(ID_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid_us (valid_us),
        .stall_us (stall_us),
        .dest_us  (dest_us),
        .data_us  (data_us),
        .valid_ds (valid_ds),
        .stall_ds (stall_ds),
        .data_ds  (data_ds),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model state: one queue per channel, round-robin pointer, pending drop pulse
    logic [WIDTH-1:0] m_q [NUM_OUT][$];
    int               m_rr;
    logic             m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_OUT; i++) m_q[i].delete();
        m_rr   = 0;
        m_drop = 1'b0;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NUM_OUT; i++) begin
            chk($sformatf("valid_ds[%0d]", i), 32'(valid_ds[i]), 32'(m_q[i].size() != 0));
            if (m_q[i].size() != 0)
                chk($sformatf("data_ds[%0d]", i), 32'(data_ds[i]), 32'(m_q[i][0]));
        end
        chk("drop", 32'(drop), 32'(m_drop));
    endtask

    initial begin
        bit   full [NUM_OUT];
        bit   exp_stall;
        int   tgt;
        int   d;
        int   r;
        int   stall_pct;

        rst      = 1'b0;
        valid_us = 1'b0;
        dest_us  = '0;
        data_us  = '0;
        stall_ds = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset valid_ds", 32'(valid_ds), 32'h0);
        chk("reset drop", 32'(drop), 32'h0);
        chk("reset stall_us", 32'(stall_us), 32'h0);
        rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_outputs();

            // Asynchronous reset in the middle of traffic
            if (cyc == 1100 || cyc == 2400) begin
                rst      = 1'b0;
                valid_us = 1'b0;
                #1;
                chk("mid-reset valid_ds", 32'(valid_ds), 32'h0);
                chk("mid-reset drop", 32'(drop), 32'h0);
                chk("mid-reset stall_us", 32'(stall_us), 32'h0);
                model_clear();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                continue;
            end

            case ((cyc / 150) % 3)
                0:       stall_pct = 10;
                1:       stall_pct = 50;
                default: stall_pct = 95;
            endcase
            for (int i = 0; i < NUM_OUT; i++)
                stall_ds[i] = ($urandom_range(0, 99) < stall_pct);
            valid_us = ($urandom_range(0, 99) < 80);
            r = $urandom_range(0, 9);
            if (r < 4)       dest_us = ID_W'(r);
            else if (r == 8) dest_us = ID_W'($urandom_range(NUM_OUT, 6));
            else             dest_us = ANY;
            data_us = WIDTH'($urandom);
            #1;

            for (int i = 0; i < NUM_OUT; i++) full[i] = (m_q[i].size() == DEPTH);
            d         = int'(dest_us);
            exp_stall = 1'b0;
            tgt       = -1;
            if (valid_us) begin
                if (d < NUM_OUT) begin
                    exp_stall = full[d];
                end else if (dest_us == ANY) begin
                    for (int k = 0; k < NUM_OUT; k++)
                        if (tgt < 0 && !full[(m_rr + k) % NUM_OUT]) tgt = (m_rr + k) % NUM_OUT;
                    exp_stall = (tgt < 0);
                end
            end
            chk("stall_us", 32'(stall_us), 32'(exp_stall));

            for (int i = 0; i < NUM_OUT; i++)
                if (m_q[i].size() != 0 && !stall_ds[i]) void'(m_q[i].pop_front());
            m_drop = 1'b0;
            if (valid_us && !exp_stall) begin
                if (d < NUM_OUT) begin
                    m_q[d].push_back(data_us);
                end else if (dest_us == ANY) begin
                    m_q[tgt].push_back(data_us);
                    m_rr = (tgt + 1) % NUM_OUT;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end

        @(negedge clk);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
